lpm_concat_packer: RTL and testbench

LPM_CONCAT_PACKER -- requirements
Module: lpm_concat_packer

---
 rtl/lpm_concat_pkg.sv | 12 +
 rtl/lpm_concat_mask.sv | 18 +
 rtl/lpm_concat_packer.sv | 117 +++++++++++
 tb/tb_lpm_concat_packer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpm_concat_pkg.sv
// Shared FSM state type and default widths for the LSB-first field packer.
package lpm_concat_pkg;

    localparam int unsigned DEF_IN_W  = 24;
    localparam int unsigned DEF_OUT_W = 32;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/lpm_concat_mask.sv
// Combinational field masker: clears every in_data bit at or above len.
module lpm_concat_mask #(
    parameter int unsigned IN_W  = 24,
    parameter int unsigned LEN_W = $clog2(IN_W + 1)
) (
    input  logic [IN_W-1:0]  data,
    input  logic [LEN_W-1:0] len,
    output logic [IN_W-1:0]  masked
);

    always_comb begin
        masked = '0;
        for (int i = 0; i < IN_W; i++) begin
            masked[i] = data[i] & (i < int'(len));
        end
    end

endmodule

// File: rtl/lpm_concat_packer.sv
// Packs variable-length fields LSB-first into OUT_W-bit words with flush support.
// Optional out_parity port is enabled by defining LPM_CONCAT_PARITY_EN.
module lpm_concat_packer
    import lpm_concat_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned LEN_W = $clog2(IN_W + 1)
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [IN_W-1:0]                   in_data,
    input  logic [LEN_W-1:0]                  in_len,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              flush,
    output logic [OUT_W-1:0]                  out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
`ifdef LPM_CONCAT_PARITY_EN
    output logic                              out_parity,
`endif
    output logic [$clog2(OUT_W+IN_W+1)-1:0]   fill_level
);

    localparam int unsigned BUF_W = OUT_W + IN_W;
    localparam int unsigned CNT_W = $clog2(BUF_W + 1);

    state_e           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d, buf_s;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_s;
    logic [IN_W-1:0]  field;
    logic             word_xfer, field_xfer;

    lpm_concat_mask #(
        .IN_W  (IN_W),
        .LEN_W (LEN_W)
    ) u_mask (
        .data   (in_data),
        .len    (in_len),
        .masked (field)
    );

    // in_ready is gated by reset_n so every output reads 0 while reset is held.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                in_ready  = reset_n && (cnt_q < CNT_W'(OUT_W));
                out_valid = (cnt_q >= CNT_W'(OUT_W));
            end
            ST_FLUSH: begin
                out_valid = (cnt_q != '0);
                out_last  = (cnt_q <= CNT_W'(OUT_W));
            end
            default: ;
        endcase
    end

    // Shift out first, then append at the post-shift count.
    always_comb begin
        word_xfer  = out_valid && out_ready;
        field_xfer = in_valid && in_ready;
        buf_s      = buf_q;
        cnt_s      = cnt_q;
        if (word_xfer) begin
            buf_s = buf_q >> OUT_W;
            cnt_s = (cnt_q > CNT_W'(OUT_W)) ? cnt_q - CNT_W'(OUT_W) : '0;
        end
        buf_d = buf_s;
        cnt_d = cnt_s;
        if (field_xfer) begin
            buf_d = buf_s | (BUF_W'(field) << cnt_s);
            cnt_d = cnt_s + CNT_W'(in_len);
        end
        state_d = state_q;
        unique case (state_q)
            ST_FILL: begin
                if (flush && (cnt_d != '0)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (word_xfer && out_last) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    buf_d   = '0;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FILL;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bits above the count are always zero, so a partial word is zero-padded.
    assign out_data   = buf_q[OUT_W-1:0];
    assign fill_level = cnt_q;

`ifdef LPM_CONCAT_PARITY_EN
    assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_lpm_concat_packer.sv
// Self-checking bench for lpm_concat_packer against a bit-queue reference model.
module tb_lpm_concat_packer;

    localparam int unsigned IN_W   = 24;
    localparam int unsigned OUT_W  = 32;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned FILL_W = 6;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [IN_W-1:0]   in_data = '0;
    logic [LEN_W-1:0]  in_len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic [FILL_W-1:0] fill_level;
`ifdef LPM_CONCAT_PARITY_EN
    logic              out_parity;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: buffered bits in arrival order, plus a "draining" flag.
    bit mq[$];
    bit mflush = 1'b0;

    always #5 clock = ~clock;

    lpm_concat_packer #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .LEN_W (LEN_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_len     (in_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
`ifdef LPM_CONCAT_PARITY_EN
        .out_parity (out_parity),
`endif
        .fill_level (fill_level)
    );

    function automatic logic [OUT_W-1:0] exp_data();
        logic [OUT_W-1:0] d = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            if (i < mq.size()) d[i] = mq[i];
        end
        return d;
    endfunction

    function automatic logic exp_ready();
        return !mflush && (mq.size() < int'(OUT_W));
    endfunction

    function automatic logic exp_valid();
        return mflush ? (mq.size() > 0) : (mq.size() >= int'(OUT_W));
    endfunction

    function automatic logic exp_last();
        return mflush && (mq.size() <= int'(OUT_W));
    endfunction

    // One clock: model follows the handshakes seen on the current inputs.
    task automatic tick();
        logic             wx   = exp_valid() && out_ready;
        logic             lst  = exp_last();
        logic             fx   = exp_ready() && in_valid;
        logic             fl   = flush;
        logic             was  = mflush;
        logic [IN_W-1:0]  d    = in_data;
        int               len  = int'(in_len);
        @(posedge clock);
        if (wx) begin
            for (int i = 0; i < int'(OUT_W) && mq.size() > 0; i++) void'(mq.pop_front());
            if (lst) mflush = 1'b0;
        end
        if (fx) begin
            for (int i = 0; i < len; i++) mq.push_back(d[i]);
        end
        if (!was && fl && mq.size() > 0) mflush = 1'b1;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        mq.delete();
        mflush = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_last, in_ready, out_data, fill_level} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b l=%b r=%b d=%h f=%0d required all zero",
                     out_valid, out_last, in_ready, out_data, fill_level);
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || fill_level !== '0) begin
            tests_failed++;
            $display("FAIL reset_release: got r=%b v=%b f=%0d required r=1 v=0 f=0",
                     in_ready, out_valid, fill_level);
        end
        @(negedge clock);
    endtask

    task automatic test_directed();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_len    = 5'd24;
        in_data   = 24'hABCDEF;
        tick();
        in_data = 24'h123456;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h56ABCDEF || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_word: got v=%b d=%h l=%b required v=1 d=56abcdef l=0",
                     out_valid, out_data, out_last);
        end
`ifdef LPM_CONCAT_PARITY_EN
        tests_run++;
        if (out_parity !== 1'b1) begin
            tests_failed++;
            $display("FAIL parity_word: got %b required 1", out_parity);
        end
`endif
        tick();
        tests_run++;
        if (fill_level !== 6'd16 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_word: got f=%0d v=%b required f=16 v=0", fill_level, out_valid);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== 32'h00001234
            || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_word: got v=%b l=%b d=%h r=%b required v=1 l=1 d=00001234 r=0",
                     out_valid, out_last, out_data, in_ready);
        end
        tick();
        tests_run++;
        if (fill_level !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_flush: got f=%0d r=%b v=%b required f=0 r=1 v=0",
                     fill_level, in_ready, out_valid);
        end
    endtask

    task automatic test_nibbles();
        do_reset();
        in_data  = 24'hFFFFFF;
        in_len   = 5'd4;
        in_valid = 1'b1;
        repeat (4) tick();
        in_len = 5'd0;
        tick();
        tests_run++;
        if (fill_level !== 6'd16 || out_data !== 32'h0000FFFF) begin
            tests_failed++;
            $display("FAIL zero_len: got f=%0d d=%h required f=16 d=0000ffff", fill_level, out_data);
        end
        in_len = 5'd4;
        repeat (4) tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_data !== 32'hFFFFFFFF || fill_level !== 6'd32 || out_valid !== 1'b1
            || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL nibble_word: got d=%h f=%0d v=%b r=%b required d=ffffffff f=32 v=1 r=0",
                     out_data, fill_level, out_valid, in_ready);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_data !== '0 || fill_level !== '0) begin
            tests_failed++;
            $display("FAIL nibble_leak: got d=%h f=%0d required d=0 f=0", out_data, fill_level);
        end
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] held;
        do_reset();
        in_valid = 1'b1;
        in_len   = 5'd24;
        repeat (3) begin
            in_data = IN_W'($urandom);
            tick();
        end
        held = out_data;
        tests_run++;
        if (fill_level !== 6'd48 || in_ready !== 1'b0 || out_data !== exp_data()) begin
            tests_failed++;
            $display("FAIL bp_full: got f=%0d r=%b d=%h required f=48 r=0 d=%h",
                     fill_level, in_ready, out_data, exp_data());
        end
        for (int i = 0; i < 4; i++) begin
            in_data = IN_W'($urandom);
            tick();
            tests_run++;
            if (out_data !== held || out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_stable: got d=%h v=%b required d=%h v=1", out_data, out_valid, held);
            end
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (fill_level !== 6'd16 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: got f=%0d r=%b required f=16 r=1", fill_level, in_ready);
        end
        tick();
        tests_run++;
        if (fill_level !== FILL_W'(mq.size()) || out_data !== exp_data()) begin
            tests_failed++;
            $display("FAIL bp_refill: got f=%0d d=%h required f=%0d d=%h",
                     fill_level, out_data, mq.size(), exp_data());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_len    = LEN_W'($urandom_range(0, IN_W));
            in_data   = IN_W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            tests_run++;
            if (out_data !== exp_data() || out_valid !== exp_valid() || out_last !== exp_last()
                || in_ready !== exp_ready() || fill_level !== FILL_W'(mq.size())) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: got d=%h v=%b l=%b r=%b f=%0d required d=%h v=%b l=%b r=%b f=%0d",
                         cyc, out_data, out_valid, out_last, in_ready, fill_level,
                         exp_data(), exp_valid(), exp_last(), exp_ready(), mq.size());
            end
`ifdef LPM_CONCAT_PARITY_EN
            tests_run++;
            if (out_parity !== ^exp_data()) begin
                tests_failed++;
                $display("FAIL random_parity%0d: got %b required %b", cyc, out_parity, ^exp_data());
            end
`endif
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        in_valid = 1'b1;
        in_len   = 5'd24;
        repeat (2) begin
            in_data = IN_W'($urandom);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL enter_flush: got v=%b l=%b r=%b required v=1 l=0 r=0",
                     out_valid, out_last, in_ready);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_last, in_ready, out_data, fill_level} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_flush: got v=%b l=%b r=%b d=%h f=%0d required all zero",
                     out_valid, out_last, in_ready, out_data, fill_level);
        end
        mq.delete();
        mflush = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || fill_level !== '0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL empty_flush: got v=%b f=%0d r=%b required v=0 f=0 r=1",
                     out_valid, fill_level, in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_flush_hold: got v=%b l=%b required v=0 l=0", out_valid, out_last);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_nibbles();
        test_backpressure();
        test_random();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
